rc_arming_failsafe: RTL and testbench

Sits between `receiver` and `angle_controller`; all logic runs on the 1 MHz `us_clk`. Each receiver channel is gated through an arming state machine: stick-gesture arm/disarm, and loss-of-link detection on the raw PWM lines. On link loss, throttle is ramped down to zero, then the block disarms. `angle_controller` only ever sees safe, registered stick values.

---
 rtl/rc_arming_failsafe.sv | 219 +++++++++++++++++++++
 tb/tb_rc_arming_failsafe.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc_arming_failsafe.sv
`default_nettype none
// ============================================================================
// Module   : rc_arming_failsafe
// Purpose  : Arming state machine and loss-of-link failsafe between the
//            receiver decoder and angle_controller.
// Revision : 1.0
// ============================================================================
module rc_arming_failsafe #(
    parameter int REC_VAL_BIT_WIDTH = 8,
    parameter int SIGNAL_TIMEOUT_US = 50000,
    parameter int ARM_HOLD_US       = 1000000,
    parameter int THROTTLE_LOW_MAX  = 10,
    parameter int YAW_HIGH_MIN      = 245,
    parameter int YAW_LOW_MAX       = 10,
    parameter int CENTER_VAL        = 128,
    parameter int FAILSAFE_RAMP_US  = 4000
) (
    input  logic                         us_clk,
    input  logic                         reset,
    input  logic                         throttle_pwm,
    input  logic                         yaw_pwm,
    input  logic                         roll_pwm,
    input  logic                         pitch_pwm,
    input  logic [REC_VAL_BIT_WIDTH-1:0] throttle_val,
    input  logic [REC_VAL_BIT_WIDTH-1:0] yaw_val,
    input  logic [REC_VAL_BIT_WIDTH-1:0] roll_val,
    input  logic [REC_VAL_BIT_WIDTH-1:0] pitch_val,
    output logic [REC_VAL_BIT_WIDTH-1:0] throttle_out,
    output logic [REC_VAL_BIT_WIDTH-1:0] yaw_out,
    output logic [REC_VAL_BIT_WIDTH-1:0] roll_out,
    output logic [REC_VAL_BIT_WIDTH-1:0] pitch_out,
    output logic                         armed,
    output logic                         failsafe,
    output logic                         link_ok,
    output logic [2:0]                   state
);

    localparam int c_CNT_W = 20;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT   = c_CNT_W'(SIGNAL_TIMEOUT_US);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(ARM_HOLD_US - 1);
    localparam logic [c_CNT_W-1:0] c_RAMP_LAST = c_CNT_W'(FAILSAFE_RAMP_US - 1);
    localparam logic [REC_VAL_BIT_WIDTH-1:0] c_CENTER   = REC_VAL_BIT_WIDTH'(CENTER_VAL);
    localparam logic [REC_VAL_BIT_WIDTH-1:0] c_THR_LOW  = REC_VAL_BIT_WIDTH'(THROTTLE_LOW_MAX);
    localparam logic [REC_VAL_BIT_WIDTH-1:0] c_YAW_HIGH = REC_VAL_BIT_WIDTH'(YAW_HIGH_MIN);
    localparam logic [REC_VAL_BIT_WIDTH-1:0] c_YAW_LOW  = REC_VAL_BIT_WIDTH'(YAW_LOW_MAX);

    typedef enum logic [2:0] {
        S_DISARMED  = 3'd0,
        S_ARMING    = 3'd1,
        S_ARMED     = 3'd2,
        S_DISARMING = 3'd3,
        S_FAILSAFE  = 3'd4
    } state_t;

    // Reset asserts asynchronously but is released in step with us_clk.
    logic [1:0] r_rst_sync;
    logic       w_rst;

    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst = r_rst_sync[1];

    logic [3:0] w_pwm;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_sync3;
    logic [3:0] w_rise;
    logic [3:0] w_alive;
    logic       r_link_ok;

    assign w_pwm  = {pitch_pwm, roll_pwm, yaw_pwm, throttle_pwm};
    assign w_rise = r_sync2 & ~r_sync3;

    always_ff @(posedge us_clk or posedge w_rst) begin
        if (w_rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sync3   <= '0;
            r_link_ok <= 1'b0;
        end else begin
            r_sync1   <= w_pwm;
            r_sync2   <= r_sync1;
            r_sync3   <= r_sync2;
            r_link_ok <= &w_alive;
        end
    end

    // Per-channel silence counters start saturated so the link is down until edges arrive.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge us_clk or posedge w_rst) begin
                if (w_rst) begin
                    r_cnt <= c_TIMEOUT;
                end else if (w_rise[gi]) begin
                    r_cnt <= '0;
                end else if (r_cnt < c_TIMEOUT) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_alive[gi] = (r_cnt < c_TIMEOUT);
        end
    endgenerate

    logic w_thr_low;
    logic w_arm_g;
    logic w_disarm_g;

    assign w_thr_low  = (throttle_val <= c_THR_LOW);
    assign w_arm_g    = w_thr_low && (yaw_val >= c_YAW_HIGH);
    assign w_disarm_g = w_thr_low && (yaw_val <= c_YAW_LOW);

    state_t                         r_state;
    state_t                         w_next;
    logic [c_CNT_W-1:0]             r_hold;
    logic [REC_VAL_BIT_WIDTH-1:0]   r_thr;
    logic [REC_VAL_BIT_WIDTH-1:0]   r_yaw;
    logic [REC_VAL_BIT_WIDTH-1:0]   r_roll;
    logic [REC_VAL_BIT_WIDTH-1:0]   r_pitch;
    logic                           r_armed;
    logic                           r_failsafe;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_DISARMED: begin
                if (w_arm_g && r_link_ok) w_next = S_ARMING;
            end
            S_ARMING: begin
                if (!w_arm_g || !r_link_ok)    w_next = S_DISARMED;
                else if (r_hold == c_HOLD_LAST) w_next = S_ARMED;
            end
            S_ARMED: begin
                if (!r_link_ok)      w_next = S_FAILSAFE;
                else if (w_disarm_g) w_next = S_DISARMING;
            end
            S_DISARMING: begin
                if (!r_link_ok)                 w_next = S_FAILSAFE;
                else if (!w_disarm_g)           w_next = S_ARMED;
                else if (r_hold == c_HOLD_LAST) w_next = S_DISARMED;
            end
            S_FAILSAFE: begin
                // Link recovery is ignored here; only an empty throttle ends failsafe.
                if (r_thr == '0) w_next = S_DISARMED;
            end
            default: w_next = S_DISARMED;
        endcase
    end

    always_ff @(posedge us_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state    <= S_DISARMED;
            r_hold     <= '0;
            r_thr      <= '0;
            r_yaw      <= c_CENTER;
            r_roll     <= c_CENTER;
            r_pitch    <= c_CENTER;
            r_armed    <= 1'b0;
            r_failsafe <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_armed    <= (w_next == S_ARMED);
            r_failsafe <= (w_next == S_FAILSAFE);

            // The hold counter doubles as the ramp-step timer while in failsafe.
            if (w_next != r_state) begin
                r_hold <= '0;
            end else if (r_state == S_FAILSAFE && r_hold == c_RAMP_LAST) begin
                r_hold <= '0;
            end else if (r_state != S_DISARMED && r_state != S_ARMED) begin
                r_hold <= r_hold + 1'b1;
            end

            case (w_next)
                S_ARMED, S_DISARMING: begin
                    r_thr   <= throttle_val;
                    r_yaw   <= yaw_val;
                    r_roll  <= roll_val;
                    r_pitch <= pitch_val;
                end
                S_FAILSAFE: begin
                    r_yaw   <= c_CENTER;
                    r_roll  <= c_CENTER;
                    r_pitch <= c_CENTER;
                    // On entry throttle holds its last armed value; afterwards it ramps.
                    if (r_state == S_FAILSAFE && r_hold == c_RAMP_LAST && r_thr != '0) begin
                        r_thr <= r_thr - 1'b1;
                    end
                end
                default: begin
                    r_thr   <= '0;
                    r_yaw   <= c_CENTER;
                    r_roll  <= c_CENTER;
                    r_pitch <= c_CENTER;
                end
            endcase
        end
    end

    assign throttle_out = r_thr;
    assign yaw_out      = r_yaw;
    assign roll_out     = r_roll;
    assign pitch_out    = r_pitch;
    assign armed        = r_armed;
    assign failsafe     = r_failsafe;
    assign link_ok      = r_link_ok;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rc_arming_failsafe.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc_arming_failsafe
// Purpose  : Directed/randomized self-checking bench for rc_arming_failsafe.
// Revision : 1.0
// ============================================================================
module tb_rc_arming_failsafe;

    localparam int W        = 8;
    localparam int TIMEOUT  = 100;
    localparam int HOLD     = 50;
    localparam int RAMP     = 4;
    localparam int PWM_PER  = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   pwm;      // {pitch, roll, yaw, throttle}
    logic [W-1:0] thr_v, yaw_v, roll_v, pitch_v;
    logic [W-1:0] throttle_out, yaw_out, roll_out, pitch_out;
    logic         armed, failsafe, link_ok;
    logic [2:0]   state;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit [3:0] pwm_en = 4'h0;
    int   last_edge [4];

    rc_arming_failsafe #(
        .REC_VAL_BIT_WIDTH (W),
        .SIGNAL_TIMEOUT_US (TIMEOUT),
        .ARM_HOLD_US       (HOLD),
        .THROTTLE_LOW_MAX  (10),
        .YAW_HIGH_MIN      (245),
        .YAW_LOW_MAX       (10),
        .CENTER_VAL        (128),
        .FAILSAFE_RAMP_US  (RAMP)
    ) dut (
        .us_clk       (clk),
        .reset        (rst),
        .throttle_pwm (pwm[0]),
        .yaw_pwm      (pwm[1]),
        .roll_pwm     (pwm[2]),
        .pitch_pwm    (pwm[3]),
        .throttle_val (thr_v),
        .yaw_val      (yaw_v),
        .roll_val     (roll_v),
        .pitch_val    (pitch_v),
        .throttle_out (throttle_out),
        .yaw_out      (yaw_out),
        .roll_out     (roll_out),
        .pitch_out    (pitch_out),
        .armed        (armed),
        .failsafe     (failsafe),
        .link_ok      (link_ok),
        .state        (state)
    );

    // PWM source: one rising edge per PWM_PER cycles on every enabled channel.
    initial begin
        int phase;
        phase = 0;
        pwm   = 4'h0;
        for (int c = 0; c < 4; c++) last_edge[c] = -1000;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int c = 0; c < 4; c++) begin
                if (phase == 0 && pwm_en[c]) begin
                    pwm[c]       = 1'b1;
                    last_edge[c] = cyc;
                end else if (phase == 5) begin
                    pwm[c] = 1'b0;
                end
            end
            phase = (phase == PWM_PER - 1) ? 0 : phase + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Holds an arm gesture until armed rises; n = cycles from gesture start.
    task automatic do_arm(input logic [W-1:0] t_arm, output int n);
        thr_v = t_arm;
        yaw_v = W'($urandom_range(245, 255));
        n = 0;
        do begin
            tick();
            n++;
        end while (!armed && n < HOLD + 30);
    endtask

    task automatic wait_link(output int n);
        n = 0;
        while (!link_ok && n < 60) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, j, t, fs_cyc, drop_cyc, last;
        logic [W-1:0] tv, yv, rv, pv;

        rst = 1'b1; thr_v = '0; yaw_v = 8'd128; roll_v = 8'd128; pitch_v = 8'd128;
        repeat (3) tick();
        chk("rst_state",    32'(state), 0);
        chk("rst_throttle", 32'(throttle_out), 0);
        chk("rst_centers",  {8'd0, yaw_out, roll_out, pitch_out}, {8'd0, 8'd128, 8'd128, 8'd128});
        chk("rst_flags",    {29'd0, armed, failsafe, link_ok}, 0);

        rst = 1'b0;
        repeat (4) tick();
        pwm_en = 4'hF;
        wait_link(n);
        chk("link_up", 32'(link_ok), 1);
        chk_range("link_up_latency", cyc - last_edge[0], 0, 24);

        // Arm: ARMING outputs stay safe, armed rises HOLD+1 cycles after the gesture.
        thr_v = W'($urandom_range(0, 10));
        yaw_v = W'($urandom_range(245, 255));
        tick();
        chk("arming_state",  32'(state), 1);
        chk("arming_outs",   {throttle_out, yaw_out, roll_out, pitch_out}, {8'd0, 8'd128, 8'd128, 8'd128});
        n = 1;
        while (!armed && n < HOLD + 30) begin
            tick();
            n++;
        end
        chk("arm_latency", n, HOLD + 1);
        chk("armed_state", 32'(state), 2);

        thr_v = 8'd200; roll_v = 8'd60; yaw_v = 8'd128;
        tick();
        chk("pass_thr200", 32'(throttle_out), 200);
        chk("pass_roll60", 32'(roll_out), 60);

        for (int k = 0; k < 12; k++) begin
            tv = W'($urandom_range(0, 255));
            yv = W'($urandom_range(11, 255));
            rv = W'($urandom_range(0, 255));
            pv = W'($urandom_range(0, 255));
            thr_v = tv; yaw_v = yv; roll_v = rv; pitch_v = pv;
            tick();
            chk("pass_random", {throttle_out, yaw_out, roll_out, pitch_out}, {tv, yv, rv, pv});
        end

        // Reset mid-run while armed: outputs fall back at once, before any clock.
        thr_v = 8'd150; yaw_v = 8'd128;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_state", 32'(state), 0);
        chk("midrst_outs",  {throttle_out, yaw_out, roll_out, pitch_out}, {8'd0, 8'd128, 8'd128, 8'd128});
        chk("midrst_flags", {29'd0, armed, failsafe, link_ok}, 0);
        tick();
        rst = 1'b0;
        thr_v = '0;
        wait_link(n);
        chk("relink_up", 32'(link_ok), 1);
        chk_range("relink_latency", cyc - last_edge[0], 0, 24);

        // Aborted arm: one-cycle gesture drop restarts the hold.
        thr_v = W'($urandom_range(0, 10));
        yaw_v = W'($urandom_range(245, 255));
        repeat (30) tick();
        chk("abort_arming", {29'd0, state}, 1);
        yaw_v = 8'd128;
        tick();
        chk("abort_back_disarmed", 32'(state), 0);
        yaw_v = W'($urandom_range(245, 255));
        n = 0;
        do begin
            tick();
            n++;
        end while (!armed && n < HOLD + 30);
        chk("abort_rearm_latency", n, HOLD + 1);

        // Link loss while armed: failsafe, centred sticks, throttle ramp, disarm.
        t = $urandom_range(12, 40);
        thr_v = W'(t); yaw_v = 8'd128; roll_v = W'($urandom_range(0, 255)); pitch_v = 8'd90;
        tick();
        chk("ll_thr_armed", 32'(throttle_out), t);
        pwm_en[2] = 1'b0;
        n = 0; drop_cyc = -1;
        while (!failsafe && n < 200) begin
            tick();
            n++;
            if (!link_ok && drop_cyc < 0) drop_cyc = cyc;
        end
        fs_cyc = cyc;
        last   = last_edge[2];
        chk("ll_link_drop", drop_cyc - last, 3 + TIMEOUT + 1);
        chk("ll_fs_delay",  fs_cyc - last, 3 + TIMEOUT + 2);
        chk("ll_fs_state",  32'(state), 4);
        chk("ll_fs_outs",   {throttle_out, yaw_out, roll_out, pitch_out}, {W'(t), 8'd128, 8'd128, 8'd128});
        j = 0;
        while (state == 3'd4 && j < RAMP * t + 20) begin
            tick();
            j++;
            if (state == 3'd4) chk("ll_ramp", 32'(throttle_out), t - j / RAMP);
        end
        chk("ll_fs_length", j, RAMP * t + 1);
        chk("ll_end_state", {throttle_out, 5'd0, state, 15'd0, failsafe}, 0);
        pwm_en = 4'hF;
        n = 0;
        repeat (60) begin
            tick();
            if (armed) n++;
        end
        chk("ll_no_rearm", n, 0);
        chk("ll_relinked", {29'd0, link_ok, state[1:0]}, 3'b100);

        // Disarm gesture: DISARMING with pass-through, then DISARMED.
        do_arm(W'($urandom_range(0, 10)), n);
        chk("dis_arm_latency", n, HOLD + 1);
        tv = W'($urandom_range(0, 10));
        thr_v = tv; yaw_v = W'($urandom_range(0, 10));
        tick();
        chk("dis_state", 32'(state), 3);
        chk("dis_pass_thr", 32'(throttle_out), 32'(tv));
        n = 1;
        while (state == 3'd3 && n < HOLD + 30) begin
            tick();
            n++;
        end
        chk("dis_latency", n, HOLD + 1);
        chk("dis_end", {throttle_out, yaw_out, 13'd0, state}, {8'd0, 8'd128, 16'd0});

        // Disarm hold interrupted by link loss: failsafe wins.
        do_arm(W'($urandom_range(0, 10)), n);
        chk("dfs_arm_latency", n, HOLD + 1);
        yaw_v = 8'd128;
        pwm_en[3] = 1'b0;
        repeat (PWM_PER + 5) tick();
        n = 0;
        while (cyc - last_edge[3] < 70 && n < 100) begin
            tick();
            n++;
        end
        last  = last_edge[3];
        yaw_v = W'($urandom_range(0, 10));
        tick();
        chk("dfs_disarming", 32'(state), 3);
        n = 0;
        while (state == 3'd3 && n < HOLD + 30) begin
            tick();
            n++;
        end
        chk("dfs_failsafe", 32'(state), 4);
        chk("dfs_delay", cyc - last, 3 + TIMEOUT + 2);
        n = 0;
        while (state != 3'd0 && n < 100) begin
            tick();
            n++;
        end
        chk("dfs_end", {throttle_out, 21'd0, state}, 0);

        // Failsafe entered with throttle already at zero lasts one cycle.
        pwm_en = 4'hF;
        wait_link(n);
        chk("z_link", 32'(link_ok), 1);
        do_arm(8'd0, n);
        chk("z_arm_latency", n, HOLD + 1);
        yaw_v = 8'd128;
        pwm_en[0] = 1'b0;
        n = 0;
        while (!failsafe && n < 200) begin
            tick();
            n++;
        end
        chk("z_failsafe", {throttle_out, 21'd0, state}, {8'd0, 24'd4});
        tick();
        chk("z_disarmed", {failsafe, 28'd0, state}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
